// File: rtl/fa128_seq_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
//------------------------------------------------------------------------------
// fa128_seq_arbiter : round-robin front end for a slice-serial WIDTH-bit adder
// Rev 1.0
//------------------------------------------------------------------------------
module fa128_seq_arbiter #(
   parameter int WIDTH = 128,
   parameter int SLICE = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid0,
   output logic             req_ready0,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic             cin0,
   input  logic             req_valid1,
   output logic             req_ready1,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   input  logic             cin1,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic             resp_id,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             busy
);

   localparam int NSL = WIDTH / SLICE;
   localparam int KW  = (NSL > 1) ? $clog2(NSL) : 1;
   localparam int IW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NSL - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             prio_q, prio_d;
   logic [KW-1:0]    k_q, k_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             cin_q, cin_d;
   logic             id_q, id_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             cout_q, cout_d;

   logic             idle;
   logic             grant0;
   logic             grant1;
   logic [IW-1:0]    base;
   logic [SLICE-1:0] slice_a;
   logic [SLICE-1:0] slice_b;
   logic             carry_in;
   logic [SLICE:0]   slice_sum;

   // prio_q names the requester that wins when both are valid
   assign idle   = (state_q == IDLE);
   assign grant0 = idle & req_valid0 & (~req_valid1 | ~prio_q);
   assign grant1 = idle & req_valid1 & (~req_valid0 |  prio_q);

   assign req_ready0 = grant0;
   assign req_ready1 = grant1;

   assign base      = IW'(int'(k_q) * SLICE);
   assign slice_a   = a_q[base +: SLICE];
   assign slice_b   = b_q[base +: SLICE];
   assign carry_in  = (k_q == '0) ? cin_q : carry_q;
   assign slice_sum = {1'b0, slice_a} + {1'b0, slice_b} + {{SLICE{1'b0}}, carry_in};

   always_comb begin
      state_d = state_q;
      prio_d  = prio_q;
      k_d     = k_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      cin_d   = cin_q;
      id_d    = id_q;
      s_d     = s_q;
      cout_d  = cout_q;

      case (state_q)
         IDLE: begin
            if (grant0) begin
               a_d     = a0;
               b_d     = b0;
               cin_d   = cin0;
               id_d    = 1'b0;
               prio_d  = 1'b1;
               k_d     = '0;
               state_d = ADD;
            end else if (grant1) begin
               a_d     = a1;
               b_d     = b1;
               cin_d   = cin1;
               id_d    = 1'b1;
               prio_d  = 1'b0;
               k_d     = '0;
               state_d = ADD;
            end
         end
         ADD: begin
            s_d[base +: SLICE] = slice_sum[SLICE-1:0];
            carry_d            = slice_sum[SLICE];
            if (k_q == K_LAST) begin
               cout_d  = slice_sum[SLICE];
               state_d = DONE;
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         DONE: begin
            // no accept here: the next grant waits for IDLE one cycle later
            if (resp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         prio_q  <= 1'b0;
         k_q     <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         cin_q   <= 1'b0;
         id_q    <= 1'b0;
         s_q     <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
         k_q     <= k_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cin_q   <= cin_d;
         id_q    <= id_d;
         s_q     <= s_d;
         cout_q  <= cout_d;
      end
   end

   assign resp_valid = (state_q == DONE);
   assign resp_id    = id_q;
   assign s          = s_q;
   assign cout       = cout_q;
   assign busy       = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_fa128_seq_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
//------------------------------------------------------------------------------
// tb_fa128_seq_arbiter : scoreboard bench for the shared slice-serial adder
// Rev 1.0
//------------------------------------------------------------------------------
module tb_fa128_seq_arbiter;

   localparam int WIDTH = 128;
   localparam int SLICE = 32;
   localparam int NSL   = WIDTH / SLICE;

   logic             clk = 1'b0;
   logic             rst;
   logic             req_valid0, req_ready0, cin0;
   logic             req_valid1, req_ready1, cin1;
   logic [WIDTH-1:0] a0, b0, a1, b1;
   logic             resp_valid, resp_ready, resp_id, cout, busy;
   logic [WIDTH-1:0] s;

   typedef struct {
      logic             id;
      logic [WIDTH:0]   sum;
   } exp_t;

   exp_t sb[$];
   int   acc_id[$];
   int   acc_cyc[$];
   int   checks    = 0;
   int   failures  = 0;
   int   acc_total = 0;
   int   cyc       = 0;
   int   skip0     = 0;
   int   skip1     = 0;
   logic model_prio = 1'b0;
   bit   acc0_flag = 1'b0;
   bit   acc1_flag = 1'b0;

   fa128_seq_arbiter #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid0 (req_valid0),
      .req_ready0 (req_ready0),
      .a0         (a0),
      .b0         (b0),
      .cin0       (cin0),
      .req_valid1 (req_valid1),
      .req_ready1 (req_ready1),
      .a1         (a1),
      .b1         (b1),
      .cin1       (cin1),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_id    (resp_id),
      .s          (s),
      .cout       (cout),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic note_accept(input logic id);
      exp_t e;
      e.id  = id;
      e.sum = id ? ({1'b0, a1} + {1'b0, b1} + (WIDTH+1)'(cin1))
                 : ({1'b0, a0} + {1'b0, b0} + (WIDTH+1)'(cin0));
      sb.push_back(e);
      if (req_valid0 && req_valid1) begin
         checks++;
         if (id !== model_prio) begin
            failures++;
            $display("FAIL rr_order granted=%0d required=%0d", id, model_prio);
         end
      end
      model_prio = ~id;
      if (id) begin
         skip1 = 0;
         if (req_valid0) begin
            skip0++;
            checks++;
            if (skip0 > 1) begin
               failures++;
               $display("FAIL starvation0 skips=%0d required<=1", skip0);
            end
         end
         acc1_flag = 1'b1;
      end else begin
         skip0 = 0;
         if (req_valid1) begin
            skip1++;
            checks++;
            if (skip1 > 1) begin
               failures++;
               $display("FAIL starvation1 skips=%0d required<=1", skip1);
            end
         end
         acc0_flag = 1'b1;
      end
      acc_total++;
      acc_id.push_back(int'(id));
      acc_cyc.push_back(cyc);
   endtask

   // accept monitor: the expected result is queued when the grant is seen
   initial forever begin
      @(negedge clk);
      if (rst) begin
         sb.delete();
         model_prio = 1'b0;
         skip0 = 0;
         skip1 = 0;
      end else begin
         if (req_ready0 && req_ready1) begin
            checks++;
            failures++;
            $display("FAIL dual_grant ready0=%b ready1=%b required=at most one", req_ready0, req_ready1);
         end
         if (req_valid0 && req_ready0)      note_accept(1'b0);
         else if (req_valid1 && req_ready1) note_accept(1'b1);
      end
   end

   // response monitor
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (!rst && resp_valid && resp_ready) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL resp_unexpected id=%0d sum=%0h required=no response", resp_id, {cout, s});
         end else begin
            e = sb.pop_front();
            if ({cout, s} !== e.sum || resp_id !== e.id) begin
               failures++;
               $display("FAIL resp_data id=%0d sum=%0h required id=%0d sum=%0h",
                        resp_id, {cout, s}, e.id, e.sum);
            end
         end
      end
   end

   task automatic wait_idle(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (!busy && sb.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      chk({name, "_drain"}, ok, 1'b1);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_accepts(input int target, input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         #1;
         if (acc_id.size() >= target) begin
            ok = 1'b1;
            break;
         end
      end
      chk({name, "_accept_seen"}, ok, 1'b1);
   endtask

   task automatic do_single(input logic id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic c, input logic [WIDTH:0] exp_sum, input string name);
      int n = 0;
      if (id) begin
         a1 = a; b1 = b; cin1 = c; req_valid1 = 1'b1;
      end else begin
         a0 = a; b0 = b; cin0 = c; req_valid0 = 1'b1;
      end
      @(negedge clk);
      chk({name, "_ready"}, id ? req_ready1 : req_ready0, 1'b1);
      @(posedge clk);
      #1;
      req_valid0 = 1'b0;
      req_valid1 = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         n++;
         if (resp_valid) break;
      end
      chk({name, "_latency"}, n, NSL + 1);
      chk({name, "_result"}, {resp_id, cout, s}, {id, exp_sum});
      wait_idle(name);
   endtask

   initial begin : watchdog
      #900000;
      failures++;
      $display("FAIL watchdog time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : stim
      int base;
      int target;
      bit ok;
      rst = 1'b1;
      req_valid0 = 1'b0; req_valid1 = 1'b0;
      a0 = '0; b0 = '0; cin0 = 1'b0;
      a1 = '0; b1 = '0; cin1 = 1'b0;
      resp_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs", {resp_valid, busy, resp_id, cout, s}, '0);
      chk("reset_ready", {req_ready0, req_ready1}, 2'b00);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // carry ripples through every slice
      do_single(1'b0, {WIDTH{1'b1}}, 128'd1, 1'b0, {1'b1, 128'd0}, "t1");
      // carry-in used on slice 0
      do_single(1'b1, 128'h1_0000_0000, 128'hFFFF_FFFF, 1'b1, 129'h2_0000_0000, "t2");

      // contention: continuous valids alternate and are NSL+2 apart
      base = acc_id.size();
      a0 = 128'd5;   b0 = 128'd7;   cin0 = 1'b0;
      a1 = 128'd100; b1 = 128'd200; cin1 = 1'b1;
      req_valid0 = 1'b1;
      req_valid1 = 1'b1;
      wait_accepts(base + 4, "t3");
      @(posedge clk);
      #1;
      req_valid0 = 1'b0;
      req_valid1 = 1'b0;
      if (acc_id.size() >= base + 4) begin
         chk("t3_grant0", acc_id[base],     0);
         chk("t3_grant1", acc_id[base + 1], 1);
         chk("t3_grant2", acc_id[base + 2], 0);
         chk("t3_grant3", acc_id[base + 3], 1);
         for (int i = 1; i < 4; i++)
            chk("t3_spacing", acc_cyc[base + i] - acc_cyc[base + i - 1], NSL + 2);
      end
      wait_idle("t3");

      // backpressure: DONE holds, no grants until after the handshake
      resp_ready = 1'b0;
      a0 = {1'b1, 127'd0}; b0 = {1'b1, 127'd1}; cin0 = 1'b1;
      a1 = 128'd3;         b1 = 128'd4;         cin1 = 1'b0;
      req_valid0 = 1'b1;
      req_valid1 = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (resp_valid) begin
            ok = 1'b1;
            break;
         end
      end
      chk("t4_resp_seen", ok, 1'b1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("t4_hold", {resp_valid, resp_id, cout, s, req_ready0, req_ready1},
             {1'b1, 1'b0, 1'b1, 128'd2, 1'b0, 1'b0});
      end
      @(posedge clk);
      #1;
      resp_ready = 1'b1;
      @(negedge clk);
      chk("t4_handshake_no_accept", {resp_valid, req_ready0, req_ready1}, 3'b100);
      @(negedge clk);
      chk("t4_accept_next", {busy, req_ready0, req_ready1}, 3'b001);
      @(posedge clk);
      #1;
      req_valid0 = 1'b0;
      req_valid1 = 1'b0;
      wait_idle("t4");

      // reset while slice 2 is being computed
      a0 = 128'd1; b0 = 128'd1; cin0 = 1'b0;
      req_valid0 = 1'b1;
      @(posedge clk);
      #1;
      req_valid0 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("t5_after_reset", {busy, resp_valid, cout, s}, '0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      base = acc_id.size();
      a0 = 128'hFFFF_FFFF; b0 = 128'd1;  cin0 = 1'b0;
      a1 = 128'd10;        b1 = 128'd20; cin1 = 1'b0;
      req_valid0 = 1'b1;
      req_valid1 = 1'b1;
      wait_accepts(base + 1, "t5a");
      @(posedge clk);
      #1;
      req_valid0 = 1'b0;
      wait_accepts(base + 2, "t5b");
      @(posedge clk);
      #1;
      req_valid1 = 1'b0;
      if (acc_id.size() >= base + 2) begin
         chk("t5_first_grant",  acc_id[base],     0);
         chk("t5_second_grant", acc_id[base + 1], 1);
      end
      wait_idle("t5");

      // random operands, valids and backpressure
      acc0_flag = 1'b0;
      acc1_flag = 1'b0;
      target = acc_total + 1000;
      for (int i = 0; i < 40000 && acc_total < target; i++) begin
         @(posedge clk);
         #1;
         if (acc0_flag) begin acc0_flag = 1'b0; req_valid0 = 1'b0; end
         if (acc1_flag) begin acc1_flag = 1'b0; req_valid1 = 1'b0; end
         if (!req_valid0 && $urandom_range(0, 2) == 0) begin
            a0   = {$urandom, $urandom, $urandom, $urandom};
            b0   = ($urandom_range(0, 7) == 0) ? ~a0 : {$urandom, $urandom, $urandom, $urandom};
            cin0 = 1'($urandom_range(0, 1));
            req_valid0 = 1'b1;
         end
         if (!req_valid1 && $urandom_range(0, 2) == 0) begin
            a1   = {$urandom, $urandom, $urandom, $urandom};
            b1   = ($urandom_range(0, 7) == 0) ? ~a1 : {$urandom, $urandom, $urandom, $urandom};
            cin1 = 1'($urandom_range(0, 1));
            req_valid1 = 1'b1;
         end
         resp_ready = ($urandom_range(0, 3) != 0);
      end
      chk("t6_ops_done", acc_total >= target, 1'b1);
      req_valid0 = 1'b0;
      req_valid1 = 1'b0;
      resp_ready = 1'b1;
      wait_idle("t6");
      chk("final_scoreboard_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
